// File: rtl/periodic_trigger_gen.sv
// periodic_trigger_gen
//
// Two-channel periodic trigger source with a bounded run window. A start
// pulse in IDLE latches both periods and the window length, then the block
// spends exactly `window` cycles in RUN emitting two independent pulse
// trains, spends one cycle in FIN reporting completion, and returns to IDLE.
//
// Ports:
//   clk           single clock, rising-edge
//   rst           asynchronous, active-high reset
//   start         one-cycle run request, honoured only in IDLE
//   period1/2     channel intervals in cycles (0 disables the channel)
//   window        run length in cycles (0 goes straight to FIN)
//   trig1/2       registered one-cycle trigger pulses
//   cnt1/2        saturating trigger counts for the current or last run
//   busy          high for every RUN cycle
//   done          one-cycle pulse during FIN
//   result_valid  counts are final; cleared by the next accepted start
module periodic_trigger_gen #(
    parameter int PW = 8,
    parameter int WW = 16,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [PW-1:0] period1,
    input  logic [PW-1:0] period2,
    input  logic [WW-1:0] window,
    output logic          trig1,
    output logic          trig2,
    output logic [CW-1:0] cnt1,
    output logic [CW-1:0] cnt2,
    output logic          busy,
    output logic          done,
    output logic          result_valid
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]    state;
    logic [1:0]    next_state;
    logic [WW-1:0] e;
    logic [WW-1:0] e_next;
    logic [PW-1:0] ph1;
    logic [PW-1:0] ph2;
    logic [PW-1:0] ph1_next;
    logic [PW-1:0] ph2_next;
    logic [PW-1:0] per1;
    logic [PW-1:0] per2;
    logic [WW-1:0] win;
    logic          fire1_next;
    logic          fire2_next;
    logic          accept;

    assign accept = (state == IDLE) && start;

    // Next-state and look-ahead logic. The trigger outputs are registered,
    // so we decide here whether the *next* cycle is a firing run cycle; that
    // way the first trigger is already visible in the first RUN cycle after
    // the accepted start. A period of 0 leaves the phase counter free-running
    // but the fire decision is gated off.
    always_comb begin
        next_state = state;
        e_next     = e;
        ph1_next   = ph1;
        ph2_next   = ph2;
        fire1_next = 1'b0;
        fire2_next = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    e_next   = '0;
                    ph1_next = '0;
                    ph2_next = '0;
                    if (window == '0) begin
                        next_state = FIN;
                    end else begin
                        next_state = RUN;
                        fire1_next = (period1 != '0);
                        fire2_next = (period2 != '0);
                    end
                end
            end
            RUN: begin
                e_next   = e + WW'(1);
                ph1_next = (ph1 == per1 - PW'(1)) ? '0 : ph1 + PW'(1);
                ph2_next = (ph2 == per2 - PW'(1)) ? '0 : ph2 + PW'(1);
                if (e == win - WW'(1)) begin
                    next_state = FIN;
                end else begin
                    fire1_next = (ph1_next == '0) && (per1 != '0);
                    fire2_next = (ph2_next == '0) && (per2 != '0);
                end
            end
            FIN: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs. The trigger counters add the
    // pulse currently on trig1/trig2, so each count includes a trigger at the
    // edge that closes that trigger's cycle; that is also why the final
    // counts are complete exactly when FIN (done) begins. Configuration is
    // only captured on an accepted start so mid-run input changes are inert.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            e            <= '0;
            ph1          <= '0;
            ph2          <= '0;
            per1         <= '0;
            per2         <= '0;
            win          <= '0;
            trig1        <= 1'b0;
            trig2        <= 1'b0;
            cnt1         <= '0;
            cnt2         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state <= next_state;
            e     <= e_next;
            ph1   <= ph1_next;
            ph2   <= ph2_next;
            trig1 <= fire1_next;
            trig2 <= fire2_next;
            busy  <= (next_state == RUN);
            done  <= (next_state == FIN);

            if (accept) begin
                per1 <= period1;
                per2 <= period2;
                win  <= window;
                cnt1 <= '0;
                cnt2 <= '0;
            end else begin
                if (trig1 && (cnt1 != {CW{1'b1}})) begin
                    cnt1 <= cnt1 + CW'(1);
                end
                if (trig2 && (cnt2 != {CW{1'b1}})) begin
                    cnt2 <= cnt2 + CW'(1);
                end
            end

            if (next_state == FIN) begin
                result_valid <= 1'b1;
            end else if (accept) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_periodic_trigger_gen.sv
// tb_periodic_trigger_gen
//
// Directed bench for periodic_trigger_gen. The DUT is built with a 4-bit
// trigger counter so that saturation is reachable in a short run; all other
// runs stay below 15 triggers per channel. Inputs are driven and outputs
// sampled on the falling edge, away from the active rising edge.
module tb_periodic_trigger_gen;

    localparam int PW = 8;
    localparam int WW = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [PW-1:0] period1;
    logic [PW-1:0] period2;
    logic [WW-1:0] window;
    logic          trig1;
    logic          trig2;
    logic [CW-1:0] cnt1;
    logic [CW-1:0] cnt2;
    logic          busy;
    logic          done;
    logic          result_valid;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    periodic_trigger_gen #(
        .PW(PW),
        .WW(WW),
        .CW(CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .period1     (period1),
        .period2     (period2),
        .window      (window),
        .trig1       (trig1),
        .trig2       (trig2),
        .cnt1        (cnt1),
        .cnt2        (cnt2),
        .busy        (busy),
        .done        (done),
        .result_valid(result_valid)
    );

    // One comparison: count it, report it when observed and expected differ.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present a one-cycle start with the given configuration. Returns at the
    // falling edge of the first cycle after the accepting rising edge.
    task automatic applyStimulus(input int p1, input int p2, input int w);
        period1 = PW'(p1);
        period2 = PW'(p2);
        window  = WW'(w);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Start a run and watch it cycle by cycle. Cycle k=1 is the first cycle
    // after the start edge, i.e. run cycle r=k-1. The expected trigger on run
    // cycle r is r mod P == 0 for r below the window. n1/n2 are expected pulse
    // counts, c1/c2 the expected (possibly saturated) final counters.
    // tail is how many cycles past done are observed; tail=1 ends in the
    // first IDLE cycle so the next start can follow immediately.
    task automatic doRun(input string tag, input int p1, input int p2, input int w,
                         input int n1, input int n2, input int c1, input int c2,
                         input bit disturb, input int tail);
        int          doneAt;
        int          doneCount;
        int          busyCount;
        int          pulses1;
        int          pulses2;
        int          patErr;
        int          last;
        int          r;
        bit          e1;
        bit          e2;
        logic [31:0] cnt1AtDone;
        logic [31:0] cnt2AtDone;
        logic [31:0] rvAtDone;
        doneAt     = -1;
        doneCount  = 0;
        busyCount  = 0;
        pulses1    = 0;
        pulses2    = 0;
        patErr     = 0;
        last       = w + 1 + tail;
        cnt1AtDone = 32'hFFFF_FFFF;
        cnt2AtDone = 32'hFFFF_FFFF;
        rvAtDone   = 0;
        applyStimulus(p1, p2, w);
        for (int k = 1; k <= last; k++) begin
            r  = k - 1;
            e1 = 1'b0;
            e2 = 1'b0;
            if (r < w && p1 != 0) e1 = ((r % p1) == 0);
            if (r < w && p2 != 0) e2 = ((r % p2) == 0);
            if (trig1 !== e1) patErr++;
            if (trig2 !== e2) patErr++;
            if (trig1 === 1'b1) pulses1++;
            if (trig2 === 1'b1) pulses2++;
            if (busy === 1'b1) busyCount++;
            if (k == 1 && w > 0) begin
                checkOutput({tag, "_rv_cleared"}, 32'(result_valid), 0);
                checkOutput({tag, "_cnt1_cleared"}, 32'(cnt1), 0);
            end
            if (done === 1'b1) begin
                doneCount++;
                doneAt     = k;
                cnt1AtDone = 32'(cnt1);
                cnt2AtDone = 32'(cnt2);
                rvAtDone   = 32'(result_valid);
            end
            if (disturb && k == 3) begin
                start   = 1'b1;
                period1 = 8'd7;
                period2 = 8'd3;
                window  = 16'd5;
            end
            if (disturb && k == 4) start = 1'b0;
            if (k < last) @(negedge clk);
        end
        checkOutput({tag, "_done_at"}, doneAt, w + 1);
        checkOutput({tag, "_done_count"}, doneCount, 1);
        checkOutput({tag, "_busy_cycles"}, busyCount, w);
        checkOutput({tag, "_trig1_pulses"}, pulses1, n1);
        checkOutput({tag, "_trig2_pulses"}, pulses2, n2);
        checkOutput({tag, "_trig_pattern_errs"}, patErr, 0);
        checkOutput({tag, "_cnt1"}, cnt1AtDone, c1);
        checkOutput({tag, "_cnt2"}, cnt2AtDone, c2);
        checkOutput({tag, "_rv_at_done"}, rvAtDone, 1);
        if (tail >= 2) begin
            checkOutput({tag, "_cnt1_hold"}, 32'(cnt1), c1);
            checkOutput({tag, "_rv_hold"}, 32'(result_valid), 1);
        end
    endtask

    // Main sequence: reset state, directed runs, mid-run reset, saturation
    // and a back-to-back restart.
    initial begin
        int doneSeen;
        rst     = 1'b1;
        start   = 1'b0;
        period1 = '0;
        period2 = '0;
        window  = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_trig1", 32'(trig1), 0);
        checkOutput("reset_trig2", 32'(trig2), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_done", 32'(done), 0);
        checkOutput("reset_rv", 32'(result_valid), 0);
        checkOutput("reset_cnt1", 32'(cnt1), 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] basic runs");
        doRun("p2_4_w20", 2, 4, 20, 10, 5, 10, 5, 1'b0, 2);
        doRun("p3_1_w10", 3, 1, 10, 4, 10, 4, 10, 1'b0, 2);
        doRun("p0_5_w0", 0, 5, 0, 0, 0, 0, 0, 1'b0, 2);
        doRun("p0_5_w7", 0, 5, 7, 0, 2, 0, 2, 1'b0, 2);
        doRun("disturbed", 2, 4, 20, 10, 5, 10, 5, 1'b1, 2);

        $display("[TB] reset during run");
        applyStimulus(2, 2, 20);
        repeat (5) @(negedge clk);
        checkOutput("pre_rst_cnt1", 32'(cnt1), 3);
        rst = 1'b1;
        #1;
        checkOutput("midrst_trig1", 32'(trig1), 0);
        checkOutput("midrst_trig2", 32'(trig2), 0);
        checkOutput("midrst_busy", 32'(busy), 0);
        checkOutput("midrst_done", 32'(done), 0);
        checkOutput("midrst_cnt1", 32'(cnt1), 0);
        checkOutput("midrst_cnt2", 32'(cnt2), 0);
        @(negedge clk);
        rst = 1'b0;
        doneSeen = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) doneSeen++;
        end
        checkOutput("midrst_no_done_or_busy", doneSeen, 0);
        checkOutput("midrst_rv", 32'(result_valid), 0);
        doRun("after_reset", 2, 4, 20, 10, 5, 10, 5, 1'b0, 2);

        $display("[TB] saturation and back-to-back");
        doRun("saturate", 1, 0, 20, 20, 0, 15, 0, 1'b0, 1);
        doRun("back_to_back", 3, 1, 10, 4, 10, 4, 10, 1'b0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/periodic_trigger_gen.md
# periodic_trigger_gen

Synthesizable two-channel periodic trigger source with per-channel trigger counters and a bounded run window. It produces the timed "Task 1 / Task 2 trigger" events that the team's parallel-task console demo models behaviourally. Downstream logging and scoreboard stages consume its pulses, counts and end-of-window report. After a start pulse it runs for a programmed number of cycles, emits two independent periodic pulse trains, and then reports how many times each channel fired.

## Interface
- PW, 8: width of the period inputs.
- WW, 16: width of the window input and the elapsed-cycle counter.
- CW, 16: width of each trigger counter.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE.
- period1  in  PW  channel-1 interval in cycles; sampled on an accepted start.
- period2  in  PW  channel-2 interval in cycles; sampled on an accepted start.
- window  in  WW  run length in cycles; sampled on an accepted start.
- trig1  out  1  one-cycle channel-1 trigger pulse.
- trig2  out  1  one-cycle channel-2 trigger pulse.
- cnt1  out  CW  number of channel-1 triggers in the current or last run.
- cnt2  out  CW  number of channel-2 triggers in the current or last run.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse at end of window.
- result_valid  out  1  cnt1/cnt2 hold final results; cleared by the next accepted start.

## Operation
- States: IDLE, RUN, FIN.
- IDLE, start=1:
  - Latch period1, period2 and window.
  - Clear cnt1, cnt2 and result_valid.
  - Clear elapsed counter e and phase counters ph1 and ph2.
  - Go to RUN, or go to FIN if window==0.
- RUN, each cycle with e as the cycle index starting at 0:
  - Channel n fires (trigN=1, cntN+1) when phN==0 and latched periodN!=0.
  - phN advances phN = (phN==periodN-1) ? 0 : phN+1.
  - e increments.
  - When e==window-1, go to FIN next cycle.
- FIN, exactly one cycle:
  - done=1 and result_valid set to 1.
  - No triggers fire.
  - Return to IDLE.
- Channel n fires on run cycles 0, P, 2P, …, strictly below window. Its final count is ceil(window/P), or 0 if P==0.
- Period 1 fires on every run cycle. Period 0 disables the channel for the run.
- cntN saturates at 2^CW-1; trigN still pulses after saturation.
- Both channels may fire in the same cycle. They are fully independent.
- start in RUN or FIN is ignored. Inputs changing mid-run have no effect.
- result_valid and the counts hold in IDLE until the next accepted start.

## Timing
- Reset, asynchronous: state=IDLE; trig1, trig2, busy, done, result_valid = 0; cnt1, cnt2 = 0; all internal counters = 0.
- Reset asserted mid-run aborts immediately. No done pulse is produced; result_valid stays 0.
- Accepted start on edge t:
  - RUN from edge t+1, busy=1.
  - First trigger(s) visible during cycle t+1.
  - cntN outputs are registered and include a trigger from the edge that ends its cycle.
- window=W≥1: busy high for exactly W cycles, then done high for 1 cycle, so done occurs W+1 cycles after start.
- window=0: done occurs 1 cycle after start; counts = 0.
- Back-to-back runs: start is accepted in the first IDLE cycle after FIN, so the minimum gap from done to the next busy is 2 cycles.
- trig1, trig2 and done are registered single-cycle pulses and are never asserted in IDLE.

## Test plan
- Reset, then start with period1=2, period2=4, window=20:
  - trig1 fires on run cycles 0, 2, …, 18; trig2 on 0, 4, …, 16.
  - done is 21 cycles after start; cnt1=10, cnt2=5; result_valid=1.
- period1=3, period2=1, window=10: cnt1=4 (cycles 0, 3, 6, 9) and cnt2=10; trig1 and trig2 coincide on cycle 0.
- period1=0, period2=5, window=0: done 1 cycle after start; cnt1=0, cnt2=0, and no trig pulses ever. Repeat with window=7: cnt1=0, cnt2=2.
- Start pulsed again mid-run, and period inputs changed mid-run: run unaffected; results identical to the undisturbed run.
- rst asserted at run cycle 5 of a period=2, window=20 run: all outputs 0 immediately, no done pulse; a fresh start afterwards gives cnt1=10.
- CW=4, period1=1, window=20: cnt1 saturates at 15 while trig1 pulses on all 20 cycles. Then start a second run immediately after done: result_valid drops on acceptance and the counts restart from 0.
